// File: rtl/barrel_shifter_pipe.sv
// Pipelined left/right barrel shifter (logical, arithmetic, rotate) with a
// stall-propagating valid/ready handshake; registers follow the stages set in PIPE_MASK.
module barrel_shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW = $clog2(WIDTH),
    parameter logic [SHW-1:0] PIPE_MASK = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shl_stage(input logic [WIDTH-1:0] v, input int n,
                                                   input logic rot, input logic fill);
        logic [WIDTH-1:0] r;
        r = v << n;
        if (rot) r = r | (v >> (WIDTH - n));
        else if (fill) r = r | ~({WIDTH{1'b1}} << n);
        return r;
    endfunction

    logic [SHW-1:0]   vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [SHW];
    logic [WIDTH-1:0] dat_d [SHW];
    logic [SHW-1:0]   sh_q [SHW];
    logic [SHW-1:0]   sh_d [SHW];
    logic [1:0]       mode_q [SHW];
    logic [1:0]       mode_d [SHW];
    logic [SHW-1:0]   dir_q, dir_d, fill_q, fill_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_zero_q, out_zero_d;

    logic [SHW:0]     rdy;
    logic             cur_v, cur_dir, cur_fill;
    logic [WIDTH-1:0] cur_data, m_data, res;
    logic [SHW-1:0]   cur_sh;
    logic [1:0]       cur_mode;

    always_comb begin
        vld_d       = vld_q;
        dat_d       = dat_q;
        sh_d        = sh_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;

        // Ready flows backwards: a full register can take a beat only if its successor moves.
        rdy[SHW] = out_ready | ~out_valid_q;
        for (int k = SHW - 1; k >= 0; k--) begin
            if (PIPE_MASK[k]) rdy[k] = ~vld_q[k] | rdy[k+1];
            else              rdy[k] = rdy[k+1];
        end

        // Right shifts run through the left-shift datapath on the bit-reversed operand.
        cur_v    = in_valid;
        cur_dir  = in_dir;
        cur_mode = in_mode;
        cur_sh   = in_shamt;
        cur_fill = (in_mode == 2'b01) & in_dir & in_data[WIDTH-1];
        cur_data = in_dir ? bit_rev(in_data) : in_data;
        m_data   = cur_data;

        for (int k = 0; k < SHW; k++) begin
            m_data = cur_sh[k] ? shl_stage(cur_data, 1 << k, cur_mode == 2'b10, cur_fill)
                               : cur_data;
            if (PIPE_MASK[k]) begin
                if (rdy[k]) begin
                    vld_d[k] = cur_v;
                    if (cur_v) begin
                        dat_d[k]  = m_data;
                        sh_d[k]   = cur_sh;
                        mode_d[k] = cur_mode;
                        dir_d[k]  = cur_dir;
                        fill_d[k] = cur_fill;
                    end
                end
                cur_v    = vld_q[k];
                cur_data = dat_q[k];
                cur_sh   = sh_q[k];
                cur_mode = mode_q[k];
                cur_dir  = dir_q[k];
                cur_fill = fill_q[k];
            end else begin
                cur_data = m_data;
            end
        end

        res = cur_dir ? bit_rev(cur_data) : cur_data;
        if (rdy[SHW]) begin
            out_valid_d = cur_v;
            if (cur_v) begin
                out_data_d = res;
                out_zero_d = (res == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            dir_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b1;
            for (int k = 0; k < SHW; k++) begin
                dat_q[k]  <= '0;
                sh_q[k]   <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            for (int k = 0; k < SHW; k++) begin
                dat_q[k]  <= dat_d[k];
                sh_q[k]   <= sh_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: 16-bit fully pipelined instance plus
// an 8-bit unpipelined instance for latency and boundary cases.
module tb_barrel_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_shamt = '0;
    logic        in_dir = 1'b0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_zero;

    logic        in8_valid = 1'b0;
    logic        in8_ready;
    logic [7:0]  in8_data = '0;
    logic [2:0]  in8_shamt = '0;
    logic        in8_dir = 1'b0;
    logic [1:0]  in8_mode = '0;
    logic        out8_valid;
    logic [7:0]  out8_data;
    logic        out8_zero;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    bit          rand_rdy = 1'b0;
    bit          saw_full = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] held;
    int          run_len = 0;
    int          max_run = 0;
    int          cyc = 0;

    barrel_shifter_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_dir(in_dir), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    barrel_shifter_pipe #(.WIDTH(8), .PIPE_MASK(3'b000)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
        .in_shamt(in8_shamt), .in_dir(in8_dir), .in_mode(in8_mode),
        .out_valid(out8_valid), .out_ready(1'b1),
        .out_data(out8_data), .out_zero(out8_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int s,
                                              input logic dir, input logic [1:0] m);
        logic [15:0] r;
        if (s == 0)                r = d;
        else if (m == 2'b10)       r = dir ? ((d >> s) | (d << (16 - s))) : ((d << s) | (d >> (16 - s)));
        else if (dir && m == 2'b01) r = $signed(d) >>> s;
        else                       r = dir ? (d >> s) : (d << s);
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called right after a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [15:0] d, input logic [3:0] s, input logic dir,
                        input logic [1:0] m);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_dir = dir; in_mode = m;
        #1;
        while (!in_ready && w < 200) begin
            saw_full = 1'b1;
            @(negedge clk); #1;
            w++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        else exp_q.push_back(ref_shift(d, int'(s), dir, m));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            stalled = 1'b0;
            run_len = 0;
        end else begin
            if (stalled) check("stall_hold", out_data, held);
            if (out_valid && out_ready) begin
                logic [15:0] e;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_data, 16'hxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("data", out_data, e);
                    check("zero_flag", out_zero, e == 16'h0);
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
    end

    initial begin
        int lat;
        int c0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_zero", out_zero, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst8_in_ready", in8_ready, 1);
        check("rst8_out_valid", out8_valid, 0);
        @(negedge clk);

        send(16'hB00F, 4'd4, 1'b0, 2'b00);
        #1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        check("latency16", lat, 5);
        @(negedge clk);
        drain();

        send(16'h8001, 4'd3, 1'b1, 2'b01);
        send(16'h8001, 4'd3, 1'b1, 2'b00);
        send(16'h8001, 4'd3, 1'b1, 2'b10);
        send(16'h8001, 4'd0, 1'b1, 2'b01);
        send(16'h1234, 4'd5, 1'b0, 2'b11);
        drain();

        max_run = 0;
        c0 = cyc;
        for (int s = 0; s < 16; s++) send(16'h8001, 4'(s), 1'b0, 2'b10);
        check("sweep_accept_cycles", cyc - c0, 16);
        drain();
        check("sweep_no_gaps", max_run, 16);

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(16'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
        end
        drain();
        check("in_ready_fell_when_full", saw_full, 1);
        rand_rdy = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) send(16'h00FF << i, 4'd1, 1'b0, 2'b00);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        send(16'hF00D, 4'd7, 1'b1, 2'b01);
        drain();

        in8_valid = 1'b1; in8_data = 8'hFF; in8_shamt = 3'd7; in8_dir = 1'b0; in8_mode = 2'b00;
        @(negedge clk);
        in8_valid = 1'b0;
        #1;
        lat = 1;
        while (!out8_valid && lat < 10) begin
            @(negedge clk); #1;
            lat++;
        end
        check("latency8", lat, 1);
        check("w8_msb_only", out8_data, 8'h80);
        check("w8_msb_zero", out8_zero, 0);
        @(negedge clk);
        in8_valid = 1'b1; in8_data = 8'h02;
        @(negedge clk);
        in8_valid = 1'b0;
        #1;
        check("w8_valid2", out8_valid, 1);
        check("w8_shift_out", out8_data, 8'h00);
        check("w8_zero", out8_zero, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
